// File: rtl/readout_arbiter.sv
`timescale 1ns/1ps
// readout_arbiter: round-robin readout of per-channel event buffers into one
// shared output FIFO. Each event is framed as one header word {sel, bc} and
// then exactly howmany sample words. A full FIFO stalls the transfer; no word
// is lost or written twice.
//
// Ports
//   clk, rst_n  system clock (rising edge); asynchronous active-low reset
//   pending     per-channel level: an event is waiting (held until ch_ack)
//   howmany     samples per event, sampled at grant
//   bc          free-running bunch count, latched at grant
//   ch_data     channel c sample on [c*WIDTH +: WIDTH], valid the cycle after its read strobe
//   fifo_full   output FIFO full
//   ch_rd_req   one-hot read strobe to the granted channel, one cycle per sample
//   ch_ack      one-hot single-cycle pulse when the event has been transferred
//   fifo_din    word to the output FIFO (0 whenever fifo_wren is low)
//   fifo_wren   FIFO write strobe
//   sel         granted channel index
//   busy        high in any state other than IDLE
module readout_arbiter #(
    parameter int unsigned CHAN     = 8,
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned SIZE     = 8,
    parameter int unsigned BC_BITS  = 5,
    parameter int unsigned SEL_BITS = $clog2(CHAN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHAN-1:0]       pending,
    input  logic [SIZE-1:0]       howmany,
    input  logic [BC_BITS-1:0]    bc,
    input  logic [WIDTH*CHAN-1:0] ch_data,
    input  logic                  fifo_full,
    output logic [CHAN-1:0]       ch_rd_req,
    output logic [CHAN-1:0]       ch_ack,
    output logic [WIDTH-1:0]      fifo_din,
    output logic                  fifo_wren,
    output logic [SEL_BITS-1:0]   sel,
    output logic                  busy
);

    localparam int unsigned HDR_BITS = SEL_BITS + BC_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [SIZE-1:0]      cnt;
    logic [BC_BITS-1:0]   bc_l;
    logic [SEL_BITS-1:0]  last_sel;
    logic                 grant_found;
    logic [SEL_BITS-1:0]  grant_idx;
    logic [SEL_BITS-1:0]  cand_idx;
    logic [CHAN-1:0]      sel_onehot;
    logic [HDR_BITS-1:0]  header;
    logic [WIDTH-1:0]     ch_word [CHAN];

    // Unpack the flat channel data bus into one word per channel.
    always_comb begin
        for (int unsigned c = 0; c < CHAN; c++) begin
            ch_word[c] = ch_data[c*WIDTH +: WIDTH];
        end
    end

    // First pending channel searching upward from last_sel+1, wrapping round.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 1; i <= CHAN; i++) begin
            cand_idx = SEL_BITS'((32'(last_sel) + i) % CHAN);
            if (!grant_found && pending[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Grant bookkeeping: channel, word count, bunch count, round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            cnt      <= '0;
            bc_l     <= '0;
            last_sel <= SEL_BITS'(CHAN - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        sel  <= grant_idx;
                        cnt  <= howmany;
                        bc_l <= bc;
                    end
                end
                ST_WRITE: cnt      <= cnt - SIZE'(1);
                ST_DONE:  last_sel <= sel;
                default:  ;
            endcase
        end
    end

    // Next-state logic; a full FIFO holds HEADER and READ.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (grant_found) state_d = ST_HEADER;
            ST_HEADER: if (!fifo_full) state_d = (cnt != '0) ? ST_READ : ST_DONE;
            ST_READ:   if (!fifo_full) state_d = ST_WRITE;
            ST_WRITE:  state_d = (cnt == SIZE'(1)) ? ST_DONE : ST_READ;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign sel_onehot = CHAN'(1) << sel;
    assign header     = {sel, bc_l};

    // Output decode. WRITE writes unconditionally: FULL was low in the READ
    // that precedes it and nothing else writes this FIFO.
    always_comb begin
        ch_rd_req = '0;
        ch_ack    = '0;
        fifo_din  = '0;
        fifo_wren = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_HEADER: begin
                if (!fifo_full) begin
                    fifo_wren = 1'b1;
                    fifo_din  = WIDTH'(header);
                end
            end
            ST_READ: begin
                if (!fifo_full) begin
                    ch_rd_req = sel_onehot;
                end
            end
            ST_WRITE: begin
                fifo_wren = 1'b1;
                fifo_din  = ch_word[sel];
            end
            ST_DONE:  ch_ack = sel_onehot;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_readout_arbiter.sv
`timescale 1ns/1ps
// Bench for readout_arbiter: channel buffers and the FIFO are modelled in the
// bench, and every cycle is compared against an action-script reference model.
module tb_readout_arbiter;

    localparam int unsigned CHAN     = 8;
    localparam int unsigned WIDTH    = 12;
    localparam int unsigned SIZE     = 8;
    localparam int unsigned BC_BITS  = 5;
    localparam int unsigned SEL_BITS = 3;

    localparam int K_HDR = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int K_ACK = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [CHAN-1:0]       pending = '0;
    logic [SIZE-1:0]       howmany = '0;
    logic [BC_BITS-1:0]    bc = '0;
    logic [WIDTH*CHAN-1:0] ch_data = '0;
    logic                  fifo_full = 1'b0;
    logic [CHAN-1:0]       ch_rd_req;
    logic [CHAN-1:0]       ch_ack;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_wren;
    logic [SEL_BITS-1:0]   sel;
    logic                  busy;

    readout_arbiter #(
        .CHAN(CHAN), .WIDTH(WIDTH), .SIZE(SIZE), .BC_BITS(BC_BITS), .SEL_BITS(SEL_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pending(pending), .howmany(howmany), .bc(bc),
        .ch_data(ch_data), .fifo_full(fifo_full), .ch_rd_req(ch_rd_req), .ch_ack(ch_ack),
        .fifo_din(fifo_din), .fifo_wren(fifo_wren), .sel(sel), .busy(busy)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // channel-side behaviour
    logic [WIDTH-1:0] base [CHAN];
    int               rd_cnt [CHAN];
    bit               auto_repend = 1'b0;

    // observations of the last sampled cycle, plus logs
    logic             s_wren, s_busy;
    logic [WIDTH-1:0] s_din;
    logic [CHAN-1:0]  s_rd, s_ack;
    logic [SEL_BITS-1:0] s_sel;
    logic [WIDTH-1:0] words [$];
    int               rd_total;
    int               rd_while_full;
    logic [CHAN-1:0]  ack_val;

    // reference model: a script of actions per event
    typedef struct {
        int               kind;
        logic [WIDTH-1:0] word;
        int               ch;
    } slot_t;
    slot_t slots [$];
    int    m_last = CHAN - 1;
    int    m_sel  = 0;
    logic             e_wren, e_busy;
    logic [WIDTH-1:0] e_din;
    logic [CHAN-1:0]  e_rd, e_ack;
    int               e_sel;

    task automatic model_eval();
        int ch;
        slot_t s;
        e_wren = 1'b0; e_din = '0; e_rd = '0; e_ack = '0; e_busy = 1'b0;
        e_sel  = m_sel;
        if (!rst_n) begin
            slots.delete();
            m_last = CHAN - 1;
            m_sel  = 0;
            e_sel  = 0;
            return;
        end
        if (slots.size() == 0) begin
            if (pending != '0) begin
                ch = -1;
                for (int k = 1; k <= int'(CHAN); k++) begin
                    int c;
                    c = (m_last + k) % int'(CHAN);
                    if (ch < 0 && pending[c]) ch = c;
                end
                s.ch = ch;
                s.kind = K_HDR; s.word = WIDTH'(ch * (1 << BC_BITS) + int'(bc));
                slots.push_back(s);
                for (int i = 0; i < int'(howmany); i++) begin
                    s.kind = K_RD; s.word = '0;
                    slots.push_back(s);
                    s.kind = K_WR; s.word = WIDTH'(int'(base[ch]) + i);
                    slots.push_back(s);
                end
                s.kind = K_ACK; s.word = '0;
                slots.push_back(s);
                m_sel = ch;
            end
        end else begin
            e_busy = 1'b1;
            s = slots[0];
            case (s.kind)
                K_HDR: if (!fifo_full) begin
                    e_wren = 1'b1; e_din = s.word; void'(slots.pop_front());
                end
                K_RD: if (!fifo_full) begin
                    e_rd[s.ch] = 1'b1; void'(slots.pop_front());
                end
                K_WR: begin
                    e_wren = 1'b1; e_din = s.word; void'(slots.pop_front());
                end
                default: begin
                    e_ack[s.ch] = 1'b1; m_last = s.ch; void'(slots.pop_front());
                end
            endcase
        end
    endtask

    // One clock cycle: predict, sample at negedge and compare, then let the
    // channels react to the strobes just after the rising edge.
    task automatic tick();
        model_eval();
        @(negedge clk);
        s_wren = fifo_wren; s_din = fifo_din; s_rd = ch_rd_req;
        s_ack = ch_ack; s_busy = busy; s_sel = sel;
        n_chk++;
        if ({s_busy, s_wren, s_din, s_rd, s_ack, s_sel} !==
            {e_busy, e_wren, e_din, e_rd, e_ack, SEL_BITS'(e_sel)}) begin
            n_err++;
            $display("FAIL cycle t=%0t got busy=%b wren=%b din=%h rd=%h ack=%h sel=%0d, expected busy=%b wren=%b din=%h rd=%h ack=%h sel=%0d",
                     $time, s_busy, s_wren, s_din, s_rd, s_ack, s_sel,
                     e_busy, e_wren, e_din, e_rd, e_ack, e_sel);
        end
        if (s_wren) words.push_back(s_din);
        if (s_rd != '0) begin
            rd_total++;
            if (fifo_full) rd_while_full++;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < int'(CHAN); c++) begin
            if (!rst_n) begin
                rd_cnt[c] = 0;
            end else begin
                if (s_rd[c]) begin
                    ch_data[c*WIDTH +: WIDTH] = WIDTH'(int'(base[c]) + rd_cnt[c]);
                    rd_cnt[c]++;
                end
                if (s_ack[c]) begin
                    rd_cnt[c] = 0;
                    if (!auto_repend) pending[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Run one event from an IDLE cycle until its ack; t_ack = -1 on timeout.
    task automatic run_event(input int max_ticks, input logic [63:0] full_sched,
                             input bit scramble, output int t_ack);
        words.delete();
        rd_total = 0; rd_while_full = 0; ack_val = '0; t_ack = -1;
        for (int k = 1; k <= max_ticks; k++) begin
            fifo_full = full_sched[k];
            if (scramble && k >= 2) begin
                howmany = SIZE'($urandom_range(0, 9));
                bc      = BC_BITS'($urandom);
            end
            tick();
            if (s_ack != '0) begin
                t_ack = k; ack_val = s_ack;
                break;
            end
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*CHAN+1:0] seen;
        rst_n = 1'b0;
        pending = 8'h3C;
        tick();
        tick();
        n_chk++;
        if ({busy, fifo_wren, fifo_din, ch_rd_req, ch_ack, sel} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b wren=%b din=%h rd=%h ack=%h sel=%0d, expected all zero",
                     busy, fifo_wren, fifo_din, ch_rd_req, ch_ack, sel);
        end
        pending = '0;
        rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | {s_busy, s_wren, s_rd, s_ack};
        end
        n_chk++;
        if (seen !== '0) begin
            n_err++;
            $display("FAIL idle_quiet got activity=%h, expected 0", seen);
        end
    endtask

    task automatic test_single_event();
        int t;
        logic [WIDTH-1:0] exp_w [4];
        exp_w[0] = 12'h051; exp_w[1] = 12'h100; exp_w[2] = 12'h101; exp_w[3] = 12'h102;
        base[2] = 12'h100;
        pending = 8'h04; howmany = 8'd3; bc = 5'd17;
        run_event(40, '0, 1'b1, t);
        n_chk++;
        if (t !== 9 || ack_val !== 8'h04) begin
            n_err++;
            $display("FAIL single_ack got cycle=%0d ack=%h, expected cycle=9 ack=04", t, ack_val);
        end
        n_chk++;
        if (words.size() != 4) begin
            n_err++;
            $display("FAIL single_count got %0d words, expected 4", words.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (words[i] !== exp_w[i]) begin
                    n_err++;
                    $display("FAIL single_word%0d got %h, expected %h", i, words[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        base[3] = 12'h200;
        pending = 8'h08; howmany = 8'd4; bc = 5'd9;
        run_event(40, 64'h0000_0000_0000_00E0, 1'b0, t);
        n_chk++;
        if (t !== 14) begin
            n_err++;
            $display("FAIL stall_len got ack cycle=%0d, expected 14", t);
        end
        n_chk++;
        if (rd_while_full != 0 || rd_total != 4) begin
            n_err++;
            $display("FAIL stall_reads got strobes=%0d while_full=%0d, expected 4 and 0", rd_total, rd_while_full);
        end
        n_chk++;
        if (words.size() != 5) begin
            n_err++;
            $display("FAIL stall_count got %0d words, expected 5", words.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                logic [WIDTH-1:0] w;
                w = (i == 0) ? 12'h069 : WIDTH'(12'h200 + i - 1);
                n_chk++;
                if (words[i] !== w) begin
                    n_err++;
                    $display("FAIL stall_word%0d got %h, expected %h", i, words[i], w);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        int t;
        pending = 8'h80; howmany = 8'd0; bc = 5'd0;
        run_event(20, '0, 1'b0, t);
        n_chk++;
        if (t !== 3 || ack_val !== 8'h80 || words.size() != 1) begin
            n_err++;
            $display("FAIL zero_len got cycle=%0d ack=%h words=%0d, expected 3 80 1", t, ack_val, words.size());
        end else begin
            n_chk++;
            if (words[0] !== 12'h0E0) begin
                n_err++;
                $display("FAIL zero_header got %h, expected 0e0", words[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        int total;
        reset_dut();
        auto_repend = 1'b1;
        pending = 8'hFF; howmany = 8'd1;
        total = 0;
        for (int e = 0; e < 9; e++) begin
            logic [CHAN-1:0] exp_a;
            exp_a = CHAN'(1) << (e % 8);
            run_event(12, '0, 1'b0, t);
            if (e < 8) total += words.size();
            n_chk++;
            if (t !== 5 || ack_val !== exp_a) begin
                n_err++;
                $display("FAIL rr_event%0d got cycle=%0d ack=%h, expected cycle=5 ack=%h", e, t, ack_val, exp_a);
            end
        end
        pending = '0;
        auto_repend = 1'b0;
        n_chk++;
        if (total != 16) begin
            n_err++;
            $display("FAIL rr_words got %0d writes per rotation, expected 16", total);
        end
    endtask

    task automatic test_reset_mid_event();
        int t;
        logic [CHAN-1:0] acks;
        base[5] = 12'h300;
        pending = 8'h20; howmany = 8'd6; bc = 5'd11;
        for (int k = 1; k <= 6; k++) tick();
        n_chk++;
        if (ch_rd_req !== 8'h20) begin
            n_err++;
            $display("FAIL mid_read got rd=%h, expected 20", ch_rd_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, fifo_wren, fifo_din, ch_rd_req, ch_ack} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got busy=%b wren=%b din=%h rd=%h ack=%h, expected all zero",
                     busy, fifo_wren, fifo_din, ch_rd_req, ch_ack);
        end
        acks = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acks = acks | s_ack;
        end
        rst_n = 1'b1;
        n_chk++;
        if (acks !== '0 || pending !== 8'h20) begin
            n_err++;
            $display("FAIL mid_noack got ack=%h pending=%h, expected 00 20", acks, pending);
        end
        run_event(40, '0, 1'b0, t);
        n_chk++;
        if (t !== 15 || ack_val !== 8'h20 || words.size() != 7) begin
            n_err++;
            $display("FAIL mid_reread got cycle=%0d ack=%h words=%0d, expected 15 20 7", t, ack_val, words.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                logic [WIDTH-1:0] w;
                w = (i == 0) ? 12'h0AB : WIDTH'(12'h300 + i - 1);
                n_chk++;
                if (words[i] !== w) begin
                    n_err++;
                    $display("FAIL mid_word%0d got %h, expected %h", i, words[i], w);
                end
            end
        end
    endtask

    task automatic test_random();
        int guard;
        reset_dut();
        for (int c = 0; c < int'(CHAN); c++) base[c] = WIDTH'($urandom);
        pending = '0;
        for (int i = 0; i < 1500; i++) begin
            fifo_full = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 7) == 0) pending = pending | CHAN'($urandom & $urandom);
            howmany = SIZE'($urandom_range(0, 5));
            bc      = BC_BITS'($urandom);
            tick();
        end
        fifo_full = 1'b0;
        guard = 0;
        while ((pending != '0 || s_busy) && guard < 600) begin
            howmany = SIZE'($urandom_range(0, 5));
            tick();
            guard++;
        end
        n_chk++;
        if (pending !== '0 || s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain got pending=%h busy=%b, expected 00 0", pending, s_busy);
        end
    endtask

    initial begin
        for (int c = 0; c < int'(CHAN); c++) begin
            base[c] = WIDTH'(c * 16);
            rd_cnt[c] = 0;
        end
        test_reset();
        test_single_event();
        test_backpressure();
        test_zero_length();
        test_round_robin();
        test_reset_mid_event();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
